// File: rtl/seg7_pkg.sv
// Shared seven-segment constants: active-low gfedcba patterns, digit codes,
// and the pattern-to-code mapping used by the display monitor.
package seg7_pkg;

   localparam logic [3:0] CODE_MINUS = 4'hA;
   localparam logic [3:0] CODE_ERR   = 4'hE;
   localparam logic [3:0] CODE_BLANK = 4'hF;

   localparam logic [6:0] SEG_0     = 7'h40;
   localparam logic [6:0] SEG_1     = 7'h79;
   localparam logic [6:0] SEG_2     = 7'h24;
   localparam logic [6:0] SEG_3     = 7'h30;
   localparam logic [6:0] SEG_4     = 7'h19;
   localparam logic [6:0] SEG_5     = 7'h12;
   localparam logic [6:0] SEG_6     = 7'h02;
   localparam logic [6:0] SEG_7     = 7'h78;
   localparam logic [6:0] SEG_8     = 7'h00;
   localparam logic [6:0] SEG_9     = 7'h18;
   localparam logic [6:0] SEG_MINUS = 7'b0111111;
   localparam logic [6:0] SEG_BLANK = 7'b1111111;

   function automatic logic [3:0] seg_to_code(input logic [6:0] pattern);
      logic [3:0] code;
      case (pattern)
         SEG_0:     code = 4'd0;
         SEG_1:     code = 4'd1;
         SEG_2:     code = 4'd2;
         SEG_3:     code = 4'd3;
         SEG_4:     code = 4'd4;
         SEG_5:     code = 4'd5;
         SEG_6:     code = 4'd6;
         SEG_7:     code = 4'd7;
         SEG_8:     code = 4'd8;
         SEG_9:     code = 4'd9;
         SEG_MINUS: code = CODE_MINUS;
         SEG_BLANK: code = CODE_BLANK;
         default:   code = CODE_ERR;
      endcase
      return code;
   endfunction

endpackage

// File: rtl/seg7_pattern_decode.sv
// Combinational decode of one active-low segment pattern into a digit code.
module seg7_pattern_decode
   import seg7_pkg::*;
(
   input  logic [6:0] pattern_i,
   output logic [3:0] code_o
);

   assign code_o = seg_to_code(pattern_i);

endmodule

// File: rtl/seg7_frame_capture.sv
// Samples a multiplexed seven-segment bus, debounces each digit, and hands out
// one complete decoded frame at a time over a valid/ready handshake.
module seg7_frame_capture
   import seg7_pkg::*;
#(
   parameter int NDIG       = 4,
   parameter int STABLE_CYC = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [6:0]        seg,
   input  logic [NDIG-1:0]   an,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [4*NDIG-1:0] out_digits,
   output logic              out_err,
   output logic              overrun
);

   localparam int CW = $clog2(STABLE_CYC + 1);
   localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;
   localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYC);
   localparam logic [CW-1:0] CNT_PRE = CW'(STABLE_CYC - 1);

   logic [6:0]      seg_m_q, seg_s_q, seg_prev_q;
   logic [NDIG-1:0] an_m_q, an_s_q, an_prev_q;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [NDIG-1:0] mask_q, mask_d;
   logic [NDIG-1:0][3:0] work_q, work_d, frame_q, frame_d;
   logic            valid_q, valid_d, err_q, err_d, overrun_q, overrun_d;
   logic            an_valid, same, capture, accept, any_err;
   logic [IW-1:0]   idx;
   logic [3:0]      dec_code;

   // Idle bus is all ones, so the synchronizers reset high.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         seg_m_q    <= '1;
         seg_s_q    <= '1;
         seg_prev_q <= '1;
         an_m_q     <= '1;
         an_s_q     <= '1;
         an_prev_q  <= '1;
      end else begin
         // NOTE: non-blocking so every stage samples the pre-edge value of the previous one.
         seg_m_q    <= seg;
         seg_s_q    <= seg_m_q;
         seg_prev_q <= seg_s_q;
         an_m_q     <= an;
         an_s_q     <= an_m_q;
         an_prev_q  <= an_s_q;
      end
   end

   assign an_valid = $onehot(~an_s_q);
   assign same     = ({an_s_q, seg_s_q} == {an_prev_q, seg_prev_q});
   assign capture  = an_valid && same && (cnt_q == CNT_PRE);
   assign accept   = valid_q && out_ready;

   always_comb begin
      // NOTE: default first so no path through this block leaves idx unassigned (no latch).
      idx = '0;
      for (int i = 0; i < NDIG; i++) begin
         if (!an_s_q[i]) idx = IW'(i);
      end
   end

   always_comb begin
      cnt_d = cnt_q;
      if (!an_valid)           cnt_d = '0;
      else if (!same)          cnt_d = CW'(1);
      else if (cnt_q != CNT_MAX) cnt_d = cnt_q + CW'(1);
   end

   seg7_pattern_decode u_decode (
      .pattern_i (seg_s_q),
      .code_o    (dec_code)
   );

   always_comb begin
      work_d    = work_q;
      mask_d    = mask_q;
      frame_d   = frame_q;
      err_d     = err_q;
      valid_d   = valid_q;
      overrun_d = overrun_q;
      any_err   = 1'b0;

      if (capture) begin
         work_d[idx] = dec_code;
         mask_d[idx] = 1'b1;
      end
      for (int i = 0; i < NDIG; i++) begin
         if (work_d[i] == CODE_ERR) any_err = 1'b1;
      end

      // Accept is resolved before completion so a back-to-back frame loads cleanly.
      if (accept) begin
         valid_d   = 1'b0;
         overrun_d = 1'b0;
      end
      if (&mask_d) begin
         mask_d = '0;
         if (!valid_d) begin
            frame_d = work_d;
            err_d   = any_err;
            valid_d = 1'b1;
         end else begin
            overrun_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q     <= '0;
         mask_q    <= '0;
         // NOTE: the work array is reset so a reset mid-frame cannot leak stale digits.
         work_q    <= {NDIG{CODE_BLANK}};
         frame_q   <= {NDIG{CODE_BLANK}};
         valid_q   <= 1'b0;
         err_q     <= 1'b0;
         overrun_q <= 1'b0;
      end else begin
         cnt_q     <= cnt_d;
         mask_q    <= mask_d;
         work_q    <= work_d;
         frame_q   <= frame_d;
         valid_q   <= valid_d;
         err_q     <= err_d;
         overrun_q <= overrun_d;
      end
   end

   assign out_valid  = valid_q;
   assign out_digits = frame_q;
   assign out_err    = err_q;
   assign overrun    = overrun_q;

endmodule
